// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and the write-back request type
// Purpose: common constants for the register file write side and the
//          {rd, data} request carried by the ALU, the long-unit FIFO and
//          the write port.
package pipe_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of write-back requests
// Purpose: buffers long-unit results until the write port is free.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the FIFO)
//   push        - request to write push_data (accepted if not full, or
//                 if full while a pop happens in the same cycle)
//   push_data   - entry to store
//   pop         - remove the head (ignored when empty)
//   head        - current head entry (valid when !empty)
//   full, empty - occupancy flags
module wb_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // On a full FIFO the pop frees the slot the push writes into; the head is
  // read combinationally before the edge, so the overlap is safe.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - register file write-side controller and scoreboard
// Purpose: sole driver of the register file write port. Merges the
//          single-cycle ALU result (priority) with buffered long-unit
//          results, and tracks pending destination registers so decode
//          stalls on RAW/WAW hazards.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   iss_valid/ra/rb/rd         - instruction presented by decode
//   iss_stall                  - decode must hold
//   alu_valid/rd/data          - ALU result, no backpressure
//   lu_valid/ready/rd/data     - long-unit result handshake
//   wa, wda, reg_wr            - register file write port
//   pending                    - per-register pending vector (bit 0 = 0)
//   wb_err                     - sticky: write to a non-pending register
module wb_scoreboard #(
  parameter int LU_DEPTH = 2,
  parameter int NREGS    = pipe_pkg::NREGS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iss_valid,
  input  logic [pipe_pkg::REG_AW-1:0] iss_ra,
  input  logic [pipe_pkg::REG_AW-1:0] iss_rb,
  input  logic [pipe_pkg::REG_AW-1:0] iss_rd,
  output logic                       iss_stall,
  input  logic                       alu_valid,
  input  logic [pipe_pkg::REG_AW-1:0] alu_rd,
  input  logic [pipe_pkg::XLEN-1:0]   alu_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [pipe_pkg::REG_AW-1:0] lu_rd,
  input  logic [pipe_pkg::XLEN-1:0]   lu_data,
  output logic [pipe_pkg::REG_AW-1:0] wa,
  output logic [pipe_pkg::XLEN-1:0]   wda,
  output logic                       reg_wr,
  output logic [NREGS-1:0]           pending,
  output logic                       wb_err
);

  import pipe_pkg::*;

  wb_req_t          alu_req, lu_req, fifo_head, wr_req;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             iss_fire;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             wb_err_q, wb_err_d;

  assign alu_req = '{rd: alu_rd, data: alu_data};
  assign lu_req  = '{rd: lu_rd,  data: lu_data};

  wb_fifo #(
    .DEPTH (LU_DEPTH)
  ) u_lu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (lu_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Write-port arbitration: ALU first, then FIFO head. An rd=0 entry still
  // occupies the port (and pops) but never asserts reg_wr.
  always_comb begin
    wr_req   = '0;
    reg_wr   = 1'b0;
    fifo_pop = 1'b0;
    if (!reset) begin
      if (alu_valid) begin
        wr_req = alu_req;
        reg_wr = (alu_rd != '0);
      end else if (!fifo_empty) begin
        wr_req   = fifo_head;
        reg_wr   = (fifo_head.rd != '0);
        fifo_pop = 1'b1;
      end
    end
  end

  assign wa  = wr_req.rd;
  assign wda = wr_req.data;

  assign lu_ready  = !reset && (!fifo_full || fifo_pop);
  assign fifo_push = lu_valid && lu_ready;

  // Pending stays set through the write cycle itself: the register file
  // only returns the new value after the edge and there is no bypass.
  // A full FIFO forces bubbles so long-unit results cannot starve behind
  // back-to-back ALU writes.
  assign iss_stall = reset
                  || pending_q[iss_ra]
                  || pending_q[iss_rb]
                  || pending_q[iss_rd]
                  || fifo_full;

  assign iss_fire = iss_valid && !iss_stall;

  // Clear first, then set, so a set of the same bit wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_wr) pending_d[wa] = 1'b0;
    if (iss_fire && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign wb_err_d = wb_err_q || (reg_wr && !pending_q[wa]);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign pending = pending_q;
  assign wb_err  = wb_err_q;

  // The WAW stall makes a same-cycle set and clear of one register
  // impossible in correct operation.
  a_no_set_clear_collision : assert property (
    @(posedge clk) disable iff (reset)
      !(iss_fire && reg_wr && (iss_rd != '0) && (iss_rd == wa))
  );

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb/tb_wb_scoreboard.sv - scoreboard bench for wb_scoreboard
module tb_wb_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_ra, iss_rb, iss_rd;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic [4:0]  wa;
  logic [31:0] wda;
  logic        reg_wr;
  logic [31:0] pending;
  logic        wb_err;

  int tests = 0;
  int fails = 0;

  logic [36:0] exp_q [$];

  always #5 clk = ~clk;

  wb_scoreboard #(
    .LU_DEPTH (2),
    .NREGS    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_ra    (iss_ra),
    .iss_rb    (iss_rb),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_rd     (lu_rd),
    .lu_data   (lu_data),
    .wa        (wa),
    .wda       (wda),
    .reg_wr    (reg_wr),
    .pending   (pending),
    .wb_err    (wb_err)
  );

  // Monitor: every committed write must match the next expected write.
  always @(negedge clk) begin
    if (!reset && reg_wr) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got wa=%0d wda=%h, required no write", wa, wda);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wa, wda} !== e) begin
          fails++;
          $display("FAIL wr_data: got wa=%0d wda=%h, required wa=%0d wda=%h",
                   wa, wda, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    iss_valid = 0; iss_ra = 0; iss_rb = 0; iss_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lu_valid = 0;  lu_rd = 0;  lu_data = 0;
  endtask

  task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
    iss_valid = 1; iss_ra = ra; iss_rb = rb; iss_rd = rd;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d, input bit expect_wr);
    alu_valid = 1; alu_rd = rd; alu_data = d;
    if (expect_wr) exp_q.push_back({rd, d});
  endtask

  initial begin
    idle();
    reset = 1;
    alu_valid = 1; alu_rd = 5; alu_data = 32'h55;
    // Reset held for two cycles with an ALU write offered.
    for (int i = 0; i < 2; i++) begin
      cyc(); smp();
      chk("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
      chk("rst_pending", pending, 32'd0);
      chk("rst_stall", {31'b0, iss_stall}, 32'd1);
      chk("rst_lu_ready", {31'b0, lu_ready}, 32'd0);
    end
    cyc(); reset = 0; idle(); smp();
    chk("post_rst_stall", {31'b0, iss_stall}, 32'd0);
    chk("post_rst_lu_ready", {31'b0, lu_ready}, 32'd1);
    chk("post_rst_wb_err", {31'b0, wb_err}, 32'd0);

    // RAW: issue rd=7, then a reader of 7 stalls until the cycle after the write.
    cyc(); issue(0, 0, 7); smp();
    chk("raw_issue7_stall", {31'b0, iss_stall}, 32'd0);
    cyc(); issue(7, 0, 0); smp();
    chk("raw_stall", {31'b0, iss_stall}, 32'd1);
    chk("raw_pending7", pending, 32'h80);
    cyc(); alu(7, 32'hDEADBEEF, 1); smp();
    chk("raw_wr_cycle_reg_wr", {31'b0, reg_wr}, 32'd1);
    chk("raw_wr_cycle_stall", {31'b0, iss_stall}, 32'd1);
    cyc(); alu_valid = 0; smp();
    chk("raw_release_stall", {31'b0, iss_stall}, 32'd0);
    chk("raw_release_pending", pending, 32'd0);

    // Arbitration: ALU and long unit in the same cycle.
    cyc(); issue(0, 0, 3); smp();
    cyc(); issue(0, 0, 4); smp();
    chk("arb_issue4_stall", {31'b0, iss_stall}, 32'd0);
    cyc(); idle();
    alu(4, 32'h22, 1);
    lu_valid = 1; lu_rd = 3; lu_data = 32'h11; exp_q.push_back({5'd3, 32'h11});
    smp();
    chk("arb_alu_first_wa", {27'b0, wa}, 32'd4);
    chk("arb_lu_ready", {31'b0, lu_ready}, 32'd1);
    cyc(); idle(); smp();
    chk("arb_lu_next_wa", {27'b0, wa}, 32'd3);
    chk("arb_lu_next_wda", wda, 32'h11);
    cyc(); smp();
    chk("arb_pending_clear", pending, 32'd0);

    // FIFO full under continuous ALU activity (rd=0 keeps the port busy).
    cyc(); issue(0, 0, 10); smp();
    cyc(); issue(0, 0, 11); smp();
    cyc(); issue(0, 0, 13); smp();
    cyc(); idle(); alu(0, 32'hFFFF, 0);
    lu_valid = 1; lu_rd = 10; lu_data = 32'hA0; exp_q.push_back({5'd10, 32'hA0});
    smp();
    chk("full_push1_ready", {31'b0, lu_ready}, 32'd1);
    cyc(); lu_rd = 11; lu_data = 32'hB0; exp_q.push_back({5'd11, 32'hB0}); smp();
    chk("full_push2_ready", {31'b0, lu_ready}, 32'd1);
    cyc(); lu_valid = 0; smp();
    chk("full_ready_low", {31'b0, lu_ready}, 32'd0);
    chk("full_stall", {31'b0, iss_stall}, 32'd1);
    chk("full_pending", pending, 32'h2C00);
    cyc(); alu_valid = 0;
    lu_valid = 1; lu_rd = 13; lu_data = 32'hD0; exp_q.push_back({5'd13, 32'hD0});
    smp();
    chk("full_pop_ready", {31'b0, lu_ready}, 32'd1);
    chk("full_pop_wa", {27'b0, wa}, 32'd10);
    cyc(); lu_valid = 0; alu(0, 32'hFFFF, 0); smp();
    chk("full_still_full", {31'b0, lu_ready}, 32'd0);
    chk("full_still_stall", {31'b0, iss_stall}, 32'd1);
    cyc(); idle(); smp();
    chk("drain_wa11", {27'b0, wa}, 32'd11);
    cyc(); smp();
    chk("drain_wa13", {27'b0, wa}, 32'd13);
    cyc(); smp();
    chk("drain_pending", pending, 32'd0);
    chk("drain_stall", {31'b0, iss_stall}, 32'd0);
    chk("drain_wb_err", {31'b0, wb_err}, 32'd0);

    // x0 and WAW.
    cyc(); issue(0, 0, 0); smp();
    chk("x0_stall", {31'b0, iss_stall}, 32'd0);
    cyc(); issue(0, 0, 9); smp();
    chk("x0_pending", pending, 32'd0);
    chk("waw_first_stall", {31'b0, iss_stall}, 32'd0);
    cyc(); smp();
    chk("waw_second_stall", {31'b0, iss_stall}, 32'd1);
    chk("waw_pending9", pending, 32'h200);
    cyc(); smp();
    chk("waw_hold_stall", {31'b0, iss_stall}, 32'd1);
    cyc(); alu(9, 32'h99, 1); smp();
    chk("waw_wr_cycle_stall", {31'b0, iss_stall}, 32'd1);
    cyc(); alu_valid = 0; smp();
    chk("waw_release_stall", {31'b0, iss_stall}, 32'd0);
    cyc(); idle(); smp();
    chk("waw_reissued_pending", pending, 32'h200);
    cyc(); alu(9, 32'h9A, 1); smp();
    cyc(); idle(); smp();
    chk("waw_final_pending", pending, 32'd0);
    chk("waw_wb_err", {31'b0, wb_err}, 32'd0);

    // Error: write to a register that is not pending.
    cyc(); alu(12, 32'hC0, 1); smp();
    cyc(); idle(); smp();
    chk("err_set", {31'b0, wb_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
    end
    chk("err_sticky", {31'b0, wb_err}, 32'd1);
    cyc(); reset = 1; smp();
    chk("err_rst_stall", {31'b0, iss_stall}, 32'd1);
    cyc(); reset = 0; smp();
    chk("err_cleared", {31'b0, wb_err}, 32'd0);
    chk("err_rst_pending", pending, 32'd0);

    chk("exp_queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Write-side controller for the pipeline's 32x32 register file: the only block that drives the register file write port (wa, wda, reg_wr).
- Merges results from the single-cycle ALU with results from a variable-latency unit (load/mul-div) that uses a valid/ready handshake and is buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode never reads, or re-targets, a register whose write has not yet committed.

Parameters:
- LU_DEPTH, 2, entries in the long-unit result FIFO (power of two, >=2).
- NREGS, 32, architectural registers; x0 is hardwired zero.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  decode presents an instruction.
- iss_ra  in  5  source register A.
- iss_rb  in  5  source register B.
- iss_rd  in  5  destination register; 0 = no write.
- iss_stall  out  1  decode must hold; issue fires when iss_valid && !iss_stall.
- alu_valid  in  1  ALU result this cycle; no backpressure.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- lu_valid  in  1  long-unit result offered.
- lu_ready  out  1  FIFO can accept.
- lu_rd  in  5  long-unit destination.
- lu_data  in  32  long-unit result.
- wa  out  5  register file write address.
- wda  out  32  register file write data.
- reg_wr  out  1  register file write enable.
- pending  out  32  scoreboard vector; bit 0 is always 0.
- wb_err  out  1  sticky: a write committed to a non-pending register.

Behaviour:
- Reset: while reset is high at a clk edge, pending=0, FIFO empty, wb_err=0. During reset, reg_wr=0, wa=0, wda=0, lu_ready=0 and iss_stall=1. Any in-flight results are dropped.
- Write-port arbitration (combinational to wa/wda/reg_wr):
  - ALU has priority: if alu_valid, then wa=alu_rd, wda=alu_data, reg_wr=(alu_rd!=0).
  - Otherwise, if the FIFO is non-empty, drive the FIFO head and pop it at the edge.
  - Otherwise reg_wr=0, wa=0, wda=0.
- FIFO:
  - Push when lu_valid && lu_ready.
  - lu_ready = !full, or full with a pop this cycle.
  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
  - Pointers wrap modulo LU_DEPTH.
  - An entry with lu_rd=0 is popped without asserting reg_wr.
- Scoreboard:
  - Set pending[iss_rd] at the edge of an issue fire with iss_rd!=0.
  - Clear pending[wa] at the edge when reg_wr=1.
  - Set and clear of the same bit in one cycle: set wins. This is unreachable under the stall rules; assert it never happens.
  - pending[0] is constant 0.
- Stall (combinational):
  - iss_stall = reset, or pending[iss_ra], or pending[iss_rb] (RAW), or pending[iss_rd] (WAW), or FIFO full.
  - FIFO full forces bubbles so the long unit cannot starve behind back-to-back ALU writes.
  - pending stays 1 during the write cycle itself, because the register file returns the old value until the edge. A dependent read therefore releases the cycle after reg_wr. There is no bypass.
- wb_err: set when reg_wr=1 and pending[wa]=0. It stays set until reset.
- Latency:
  - An ALU result is written in its arrival cycle.
  - A long-unit result is written no earlier than the cycle after its handshake.
  - A stalled dependent issues 1 cycle after the write.

Decomposition:
- Shared package pipe_pkg:
  - REG_AW=5, XLEN=32, NREGS.
  - Struct wb_req_t {rd[4:0], data[31:0]}, used for the ALU input, the FIFO entry and the write-port output.
- One natural sub-module, wb_fifo: a parameterised sync FIFO of wb_req_t with push/pop/full/empty and simultaneous push-pop on full.
- Scoreboard and arbitration stay in the top level.

Test Plan:
- Reset: hold reset 2 cycles with alu_valid=1, alu_rd=5 -> reg_wr=0, pending=0, iss_stall=1. After release, iss_stall=0 for iss_ra=iss_rb=iss_rd=0.
- RAW stall:
  - Issue rd=7, then iss_ra=7 -> iss_stall=1.
  - ALU writes rd=7, data 0xDEADBEEF in cycle N -> wa=7, wda=0xDEADBEEF, reg_wr=1 in N. iss_stall stays 1 in N and drops to 0 in N+1. pending[7]=0 from N+1.
- Arbitration: issue rd=3 (long) and rd=4 (ALU); lu_valid rd=3 data 0x11 and alu_valid rd=4 data 0x22 in the same cycle -> ALU written first (wa=4). wa=3, wda=0x11 in the next cycle.
- FIFO full:
  - Push 2 long results during continuous alu_valid -> lu_ready=0, iss_stall=1.
  - First ALU-free cycle pops the head with lu_ready=1. A same-cycle push is accepted and count stays 2.
- x0 and WAW: issue rd=0 -> pending stays 0, no stall on ra=0. Issue rd=9 twice back-to-back -> second issue stalls until 9 is written.
- Error: ALU write to rd=12 with pending[12]=0 -> wb_err=1, and it stays 1 until reset.
